// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: main-decoder op classes, R-type
// function codes, 4-bit ALU control codes and the multiply/divide FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_BEQ   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_BNE   = 3'b111;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BEQ = 4'b1000;
  localparam logic [3:0] ALU_BNE = 4'b1001;
  localparam logic [3:0] ALU_MDU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/alu_exec_unit_mdu.sv
// Iterative multiply/divide core: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle for WIDTH cycles, with sign fix-up.
module alu_mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  // operand magnitudes and one iteration step
  always_comb begin
    if (op_signed && a[WIDTH-1]) mag_a = -a;
    else                         mag_a = a;
    if (op_signed && b[WIDTH-1]) mag_b = -b;
    else                         mag_b = b;

    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (is_div) begin
      if (!div_trial[WIDTH]) acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                   acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // iteration state: load on start, step until the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      dividend <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= '0;
      acc      <= {{WIDTH{1'b0}}, mag_a};
      opnd     <= mag_b;
      dividend <= a;
      is_div   <= op_div;
      neg_q    <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r    <= op_signed && a[WIDTH-1];
      div_zero <= op_div && (b == '0);
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (cnt == LAST) busy <= 1'b0;
      else             busy <= 1'b1;
    end else begin
      busy <= 1'b0;
    end
  end

  assign done = busy && (cnt == LAST);

  // sign fix-up; divide by zero bypasses it and reports the raw dividend
  always_comb begin
    if (neg_q) prod = -acc;
    else       prod = acc;
    if (neg_q) quot = -acc[WIDTH-1:0];
    else       quot = acc[WIDTH-1:0];
    if (neg_r) rem = -acc[2*WIDTH-1:WIDTH];
    else       rem = acc[2*WIDTH-1:WIDTH];

    if (!is_div) begin
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end else if (div_zero) begin
      hi_res = dividend;
      lo_res = '1;
    end else begin
      hi_res = rem;
      lo_res = quot;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with ALU-control decode and registered results.
// Define ALU_MDU_EN to add the iterative mult/div unit with HI/LO registers.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluop,
  input  logic [5:0]       func,
  input  logic [SH_W-1:0]  shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [3:0]       aluctl,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             dec_ill;
  logic [WIDTH-1:0] alu_raw;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             accept;
  logic             alu_load;
  logic             mdu_load;
  logic [WIDTH-1:0] mdu_lo;
`ifdef ALU_MDU_EN
  logic             dec_mfhi;
  logic             dec_mflo;
  logic             dec_mul;
  logic             dec_div;
  logic             dec_signed;
  logic             mdu_done;
  logic [WIDTH-1:0] mdu_hi;
  mdu_state_t       state;
  mdu_state_t       state_nxt;
`endif

  // ALU-control decode from the main-decoder op class and function field
  always_comb begin
    aluctl  = ALU_ADD;
    dec_ill = 1'b0;
`ifdef ALU_MDU_EN
    dec_mfhi   = 1'b0;
    dec_mflo   = 1'b0;
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    dec_signed = 1'b0;
`endif
    case (aluop)
      OP_ADD: aluctl = ALU_ADD;
      OP_BEQ: aluctl = ALU_BEQ;
      OP_BNE: aluctl = ALU_BNE;
      OP_AND: aluctl = ALU_AND;
      OP_OR:  aluctl = ALU_OR;
      OP_RTYPE: begin
        case (func)
          F_ADD: aluctl = ALU_ADD;
          F_SUB: aluctl = ALU_SUB;
          F_AND: aluctl = ALU_AND;
          F_OR:  aluctl = ALU_OR;
          F_SLL: aluctl = ALU_SLL;
          F_SRL: aluctl = ALU_SRL;
          F_SLT: aluctl = ALU_SLT;
`ifdef ALU_MDU_EN
          F_MFHI:  begin aluctl = ALU_MDU; dec_mfhi = 1'b1; end
          F_MFLO:  begin aluctl = ALU_MDU; dec_mflo = 1'b1; end
          F_MULT:  begin aluctl = ALU_MDU; dec_mul = 1'b1; dec_signed = 1'b1; end
          F_MULTU: begin aluctl = ALU_MDU; dec_mul = 1'b1; end
          F_DIV:   begin aluctl = ALU_MDU; dec_div = 1'b1; dec_signed = 1'b1; end
          F_DIVU:  begin aluctl = ALU_MDU; dec_div = 1'b1; end
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // single-cycle datapath and branch condition
  always_comb begin
    alu_raw = '0;
    case (aluctl)
      ALU_ADD:                   alu_raw = a + b;
      ALU_SUB, ALU_BEQ, ALU_BNE: alu_raw = a - b;
      ALU_AND:                   alu_raw = a & b;
      ALU_OR:                    alu_raw = a | b;
      ALU_SLL:                   alu_raw = b << shamt;
      ALU_SRL:                   alu_raw = b >> shamt;
      ALU_SLT:                   alu_raw = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_MDU_EN
      ALU_MDU: begin
        if (dec_mfhi)      alu_raw = hi;
        else if (dec_mflo) alu_raw = lo;
        else               alu_raw = '0;
      end
`endif
      default: alu_raw = '0;
    endcase
    if (dec_ill) alu_res = '0;
    else         alu_res = alu_raw;
    if (aluctl == ALU_BEQ)      alu_zero = (a == b);
    else if (aluctl == ALU_BNE) alu_zero = (a != b);
    else                        alu_zero = (alu_res == '0);
  end

`ifdef ALU_MDU_EN
  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign alu_load = accept && !(dec_mul || dec_div);
  assign mdu_load = (state == ST_DONE);

  alu_mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && (dec_mul || dec_div)),
    .op_div    (dec_div),
    .op_signed (dec_signed),
    .a         (a),
    .b         (b),
    .done      (mdu_done),
    .hi_res    (mdu_hi),
    .lo_res    (mdu_lo)
  );

  // mult/div sequencing state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // mult/div next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && dec_mul)      state_nxt = ST_MUL;
        else if (accept && dec_div) state_nxt = ST_DIV;
        else                        state_nxt = ST_IDLE;
      end
      ST_MUL, ST_DIV: begin
        if (mdu_done) state_nxt = ST_DONE;
        else          state_nxt = state;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // HI/LO written once the iteration has finished
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (mdu_load) begin
      hi <= mdu_hi;
      lo <= mdu_lo;
    end else begin
      hi <= hi;
      lo <= lo;
    end
  end
`else
  assign in_ready = 1'b1;
  assign accept   = in_valid;
  assign alu_load = accept;
  assign mdu_load = 1'b0;
  assign mdu_lo   = '0;
  assign hi       = '0;
  assign lo       = '0;
`endif

  // registered result, flags and valid pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      zero      <= 1'b0;
    end else if (alu_load) begin
      result    <= alu_res;
      out_valid <= 1'b1;
      illegal   <= dec_ill;
      zero      <= alu_zero;
    end else if (mdu_load) begin
      result    <= mdu_lo;
      out_valid <= 1'b1;
      illegal   <= 1'b0;
      zero      <= (mdu_lo == '0);
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
